// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the FIFO read-side byte serialiser.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } state_t;

    function automatic int unsigned num_bytes(input int unsigned data_width,
                                              input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus byte-stream handshake between fifo_reader and its neighbours.
interface fifo_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;
    logic [BYTE_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;

    modport master (
        input  fifo_empty, fifo_data, tx_ready,
        output fifo_pop, tx_data, tx_valid, tx_last
    );

    modport slave (
        output fifo_empty, fifo_data, tx_ready,
        input  fifo_pop, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/fifo_reader.sv
// Pops words from a registered-output FIFO and streams them out as bytes
// on a valid/ready interface, counting completed words.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fifo_reader_if.master        bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_sent
);

    localparam int unsigned NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam bit         SINGLE_BYTE = (NUM_BYTES == 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next_c;
    logic                  accept_c;
    logic                  start_c;

    // The byte on the wire is always the "head" of the shift register.
    function automatic logic [BYTE_WIDTH-1:0] head(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST) return BYTE_WIDTH'(w >> (DATA_WIDTH - BYTE_WIDTH));
        else           return BYTE_WIDTH'(w);
    endfunction

    always_comb begin
        accept_c     = bus.tx_valid && bus.tx_ready;
        start_c      = enable && !bus.fifo_empty;
        shreg_next_c = MSB_FIRST ? (shreg << BYTE_WIDTH) : (shreg >> BYTE_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bus.fifo_pop <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_last  <= 1'b0;
            bus.tx_data  <= '0;
            busy         <= 1'b0;
            words_sent   <= '0;
            idx          <= '0;
            shreg        <= '0;
        end else begin
            bus.fifo_pop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_c) begin
                        state        <= POP;
                        bus.fifo_pop <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                POP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    // FIFO data is valid here, one cycle after the pop was sampled.
                    shreg        <= bus.fifo_data;
                    idx          <= '0;
                    bus.tx_data  <= head(bus.fifo_data);
                    bus.tx_valid <= 1'b1;
                    bus.tx_last  <= SINGLE_BYTE;
                    state        <= SEND;
                end
                SEND: begin
                    if (accept_c) begin
                        if (idx == LAST_IDX) begin
                            words_sent   <= words_sent + CNT_WIDTH'(1);
                            bus.tx_valid <= 1'b0;
                            bus.tx_last  <= 1'b0;
                            idx          <= '0;
                            if (start_c) begin
                                state        <= POP;
                                bus.fifo_pop <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            shreg       <= shreg_next_c;
                            bus.tx_data <= head(shreg_next_c);
                            bus.tx_last <= ((idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: two instances (MSB-first/16-bit count and
// LSB-first/2-bit count), each fed by a small registered-output FIFO model.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable0, enable1;
    logic        busy0, busy1;
    logic [15:0] ws0;
    logic [1:0]  ws1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus0 ();
    fifo_reader_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus1 ();

    fifo_reader #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .enable(enable0), .bus(bus0.master),
        .busy(busy0), .words_sent(ws0)
    );

    fifo_reader #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .bus(bus1.master),
        .busy(busy1), .words_sent(ws1)
    );

    // FIFO models: data registered on the pop edge, empty flag registered.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        push0_en = 1'b0, push1_en = 1'b0;
    logic [31:0] push0_val = '0, push1_val = '0;
    int          pops0 = 0, pops1 = 0;
    bit          prev0 = 1'b0, prev1 = 1'b0, bad0 = 1'b0, bad1 = 1'b0;

    always @(posedge clk) begin
        if (bus0.fifo_pop === 1'b1) begin
            pops0++;
            if (prev0 || q0.size() == 0) bad0 = 1'b1;
            else bus0.fifo_data <= q0.pop_front();
        end
        prev0 = (bus0.fifo_pop === 1'b1);
        if (push0_en) q0.push_back(push0_val);
        bus0.fifo_empty <= (q0.size() == 0);
    end

    always @(posedge clk) begin
        if (bus1.fifo_pop === 1'b1) begin
            pops1++;
            if (prev1 || q1.size() == 0) bad1 = 1'b1;
            else bus1.fifo_data <= q1.pop_front();
        end
        prev1 = (bus1.fifo_pop === 1'b1);
        if (push1_en) q1.push_back(push1_val);
        bus1.fifo_empty <= (q1.size() == 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push0(input logic [31:0] v);
        push0_val = v;
        push0_en  = 1'b1;
        @(negedge clk);
        push0_en  = 1'b0;
    endtask

    task automatic push1(input logic [31:0] v);
        push1_val = v;
        push1_en  = 1'b1;
        @(negedge clk);
        push1_en  = 1'b0;
    endtask

    task automatic wait_valid(input int which, input string tag);
        int n = 0;
        while (((which == 0) ? bus0.tx_valid : bus1.tx_valid) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'((which == 0) ? bus0.tx_valid : bus1.tx_valid), 64'(1));
    endtask

    logic [7:0]  sw_bytes [4];
    bit          bp_ready [7];
    logic [7:0]  bp_data  [7];
    logic [31:0] b2b_words [3];
    logic [31:0] wr_words [5];
    logic [1:0]  wr_ws    [5];
    logic [7:0]  got_b [$];
    int          got_c [$];
    int          base;
    logic [31:0] t;

    initial begin
        sw_bytes  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        bp_ready  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp_data   = '{8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hC3, 8'hC3, 8'hD4};
        b2b_words = '{32'h32, 32'h46, 32'h5A};
        wr_words  = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h12345678};
        wr_ws     = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset = 1'b0; enable0 = 1'b0; enable1 = 1'b0;
        bus0.tx_ready = 1'b0; bus1.tx_ready = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_pop",   64'(bus0.fifo_pop), 64'(0));
        chk("rst_valid", 64'(bus0.tx_valid), 64'(0));
        chk("rst_last",  64'(bus0.tx_last),  64'(0));
        chk("rst_data",  64'(bus0.tx_data),  64'(0));
        chk("rst_busy",  64'(busy0),         64'(0));
        chk("rst_ws",    64'(ws0),           64'(0));

        // Idle with empty FIFO and enable high
        reset = 1'b1; enable0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_pop",   64'(bus0.fifo_pop), 64'(0));
            chk("idle_valid", 64'(bus0.tx_valid), 64'(0));
            chk("idle_busy",  64'(busy0),         64'(0));
            chk("idle_ws",    64'(ws0),           64'(0));
        end

        // Single word, ready always high
        bus0.tx_ready = 1'b1;
        push0(32'hA1B2C3D4);
        chk("sw_busy_idle", 64'(busy0), 64'(0));
        tick();
        chk("sw_pop_hi",  64'(bus0.fifo_pop), 64'(1));
        chk("sw_busy_hi", 64'(busy0),         64'(1));
        tick();
        chk("sw_pop_lo",  64'(bus0.fifo_pop), 64'(0));
        chk("sw_capt_nv", 64'(bus0.tx_valid), 64'(0));
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("sw_valid", 64'(bus0.tx_valid), 64'(1));
            chk("sw_data",  64'(bus0.tx_data),  64'(sw_bytes[b]));
            chk("sw_last",  64'(bus0.tx_last),  64'(b == 3));
            chk("sw_nopop", 64'(bus0.fifo_pop), 64'(0));
        end
        tick();
        chk("sw_end_valid", 64'(bus0.tx_valid), 64'(0));
        chk("sw_end_ws",    64'(ws0),           64'(1));
        chk("sw_end_busy",  64'(busy0),         64'(0));
        chk("sw_pops",      64'(pops0),         64'(1));

        // Backpressure: ready pattern 1,0,0,1,0,1,1 over the SEND cycles
        push0(32'hA1B2C3D4);
        wait_valid(0, "bp_start");
        for (int c = 0; c < 7; c++) begin
            chk("bp_valid", 64'(bus0.tx_valid), 64'(1));
            chk("bp_data",  64'(bus0.tx_data),  64'(bp_data[c]));
            chk("bp_last",  64'(bus0.tx_last),  64'(c == 6));
            bus0.tx_ready = bp_ready[c];
            tick();
        end
        chk("bp_end_valid", 64'(bus0.tx_valid), 64'(0));
        chk("bp_end_ws",    64'(ws0),           64'(2));
        bus0.tx_ready = 1'b1;

        // Back-to-back drain of three words after a fresh reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("b2b_rst_ws", 64'(ws0), 64'(0));
        base = pops0;
        push0(b2b_words[0]);
        push0(b2b_words[1]);
        push0(b2b_words[2]);
        for (int c = 0; c < 30; c++) begin
            if (bus0.tx_valid === 1'b1 && bus0.tx_ready === 1'b1) begin
                got_b.push_back(bus0.tx_data);
                got_c.push_back(c);
            end
            tick();
        end
        chk("b2b_count", 64'(got_b.size()), 64'(12));
        if (got_b.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                t = b2b_words[k / 4] >> (24 - 8 * (k % 4));
                chk("b2b_byte", 64'(got_b[k]), 64'(t[7:0]));
            end
            chk("b2b_period1", 64'(got_c[4] - got_c[0]), 64'(6));
            chk("b2b_period2", 64'(got_c[8] - got_c[4]), 64'(6));
        end
        chk("b2b_ws",    64'(ws0),          64'(3));
        chk("b2b_pops",  64'(pops0 - base), 64'(3));
        chk("b2b_empty", 64'(bad0),         64'(0));
        chk("b2b_busy",  64'(busy0),        64'(0));

        // Enable dropped during byte 1 of word 1
        enable0 = 1'b0;
        push0(32'h01020304);
        push0(32'h05060708);
        base = pops0;
        enable0 = 1'b1;
        wait_valid(0, "ed_start");
        chk("ed_b0", 64'(bus0.tx_data), 64'(8'h01));
        tick();
        chk("ed_b1", 64'(bus0.tx_data), 64'(8'h02));
        enable0 = 1'b0;
        tick();
        chk("ed_b2", 64'(bus0.tx_data), 64'(8'h03));
        tick();
        chk("ed_b3",   64'(bus0.tx_data), 64'(8'h04));
        chk("ed_last", 64'(bus0.tx_last), 64'(1));
        tick();
        chk("ed_done_valid", 64'(bus0.tx_valid), 64'(0));
        chk("ed_done_ws",    64'(ws0),           64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("ed_nopop", 64'(bus0.fifo_pop), 64'(0));
            chk("ed_idle",  64'(busy0),         64'(0));
            tick();
        end
        chk("ed_pops", 64'(pops0 - base), 64'(1));

        // Re-enable, then reset during byte 2 of word 2
        enable0 = 1'b1;
        wait_valid(0, "rs_start");
        chk("rs_b0", 64'(bus0.tx_data), 64'(8'h05));
        tick();
        chk("rs_b1", 64'(bus0.tx_data), 64'(8'h06));
        tick();
        chk("rs_b2", 64'(bus0.tx_data), 64'(8'h07));
        reset = 1'b0;
        tick();
        chk("rs_pop",   64'(bus0.fifo_pop), 64'(0));
        chk("rs_valid", 64'(bus0.tx_valid), 64'(0));
        chk("rs_last",  64'(bus0.tx_last),  64'(0));
        chk("rs_data",  64'(bus0.tx_data),  64'(0));
        chk("rs_busy",  64'(busy0),         64'(0));
        chk("rs_ws",    64'(ws0),           64'(0));
        reset = 1'b1;
        enable0 = 1'b0;

        // LSB-first instance with a 2-bit wrapping word counter
        bus1.tx_ready = 1'b1;
        for (int w = 0; w < 5; w++) push1(wr_words[w]);
        enable1 = 1'b1;
        for (int w = 0; w < 5; w++) begin
            wait_valid(1, "wr_start");
            for (int b = 0; b < 4; b++) begin
                t = wr_words[w] >> (8 * b);
                chk("wr_data", 64'(bus1.tx_data), 64'(t[7:0]));
                chk("wr_last", 64'(bus1.tx_last), 64'(b == 3));
                if (b < 3) tick();
            end
            tick();
            chk("wr_ws", 64'(ws1), 64'(wr_ws[w]));
        end
        chk("wr_pops",  64'(pops1), 64'(5));
        chk("wr_empty", 64'(bad1),  64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side companion to the team's 32-bit push/pop `fifo`.
- Drains words from the FIFO and serialises each word into bytes on a valid/ready byte stream, MSB byte first.
- Sits between the FIFO output (`data_out`, `fifo_empty`, `pop`) and a byte-wide downstream consumer, for example a UART TX or a packet framer.
- Counts words delivered.

Parameters:
- DATA_WIDTH, default 32: FIFO word width. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, default 8: output symbol width.
- MSB_FIRST, default 1: 1 sends the most-significant byte first; 0 sends the least-significant byte first.
- CNT_WIDTH, default 16: width of the words_sent counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- enable  in  1  permits starting a new word.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out.
- fifo_pop  out  1  one-cycle pop strobe to FIFO.
- tx_data  out  BYTE_WIDTH  current byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts byte.
- tx_last  out  1  high with the final byte of a word.
- busy  out  1  high in any state other than IDLE.
- words_sent  out  CNT_WIDTH  count of fully delivered words.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - fifo_pop=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, words_sent=0.
  - Byte index and shift register cleared.
- Reset mid-word: the in-flight word is discarded and is not counted. A word already popped is lost; this is accepted.
- FIFO read contract: fifo_data is valid in the cycle after the cycle in which fifo_pop was sampled high. In other words, the data is registered one cycle behind the pop edge.
- FSM states:
  - IDLE: if enable && !fifo_empty, go to POP.
  - POP: fifo_pop=1 for exactly this one cycle (registered output). Go to CAPT.
  - CAPT: load the shift register from fifo_data; byte index=0. Go to SEND.
  - SEND: tx_valid=1.
    - On tx_valid && tx_ready: advance the byte index.
    - When the accepted byte is the last one (index NUM_BYTES-1): words_sent += 1, wrapping modulo 2^CNT_WIDTH.
    - After the last byte: if enable && !fifo_empty, go to POP (back-to-back); otherwise go to IDLE.
- fifo_pop is never asserted while fifo_empty is high at the decision cycle. It is never asserted on two consecutive cycles.
- Latency: the first byte's tx_valid rises 3 cycles after the IDLE cycle that sees enable && !fifo_empty.
- With tx_ready held high, one word takes NUM_BYTES+2 cycles in back-to-back mode.
- Byte order:
  - MSB_FIRST=1: byte 0 is fifo_data[DATA_WIDTH-1 -: BYTE_WIDTH].
  - MSB_FIRST=0: byte 0 is the lowest byte.
- Backpressure: while tx_valid && !tx_ready, tx_data, tx_last and tx_valid hold stable. tx_valid never drops without a handshake, except on reset.
- tx_last=1 exactly while the byte with index NUM_BYTES-1 is presented.
- enable deasserted mid-word: the current word completes and no new pop follows.
- FIFO empties mid-word: the current word completes from the shift register; the FSM then returns to IDLE.
- Derived constant NUM_BYTES = DATA_WIDTH/BYTE_WIDTH. The byte index is $clog2(NUM_BYTES) bits wide, minimum 1.

Decomposition:
- Package fifo_reader_pkg holds:
  - the state enumeration (IDLE, POP, CAPT, SEND; 2-bit encoding);
  - the NUM_BYTES helper function.
- No sub-module. The shift/select logic stays inline. Top-level integration instantiates `fifo` plus `fifo_reader` side by side.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then keep fifo_empty=1 and enable=1. Required: fifo_pop never rises, tx_valid=0, busy=0, words_sent=0.
- Single word: push 0xA1B2C3D4, enable=1, tx_ready=1. Required:
  - exactly one fifo_pop pulse;
  - bytes A1, B2, C3, D4 on consecutive cycles;
  - tx_last only with D4;
  - words_sent=1, then the block returns to IDLE.
- Backpressure: same word, tx_ready toggles 1,0,0,1,0,1,1. Required:
  - tx_data holds each byte through the low cycles;
  - all four bytes are delivered in order, with no duplicate and no drop.
- Back-to-back drain: push 50, 70, 90 (0x32, 0x46, 0x5A), tx_ready=1. Required:
  - streams 00 00 00 32, 00 00 00 46, 00 00 00 5A;
  - 6 cycles per word;
  - words_sent=3, and fifo_pop is never asserted after the FIFO is empty.
- Enable drop and reset: with 2 words queued, drop enable during byte 1 of word 1. Required: word 1 completes and no second pop occurs. Then re-raise enable and assert reset=0 during byte 2 of word 2. Required: all outputs are at their reset values on the next cycle, and words_sent=0.
- MSB_FIRST=0 and counter wrap: with MSB_FIRST=0 and CNT_WIDTH=2, push 5 words starting 0x11223344. Required: first stream is 44 33 22 11, and words_sent goes 1, 2, 3, 0, 1.
